// File: rtl/distributed_arith.sv
// 8-tap FIR inner product via distributed arithmetic: one bit-plane per clock,
// LSB first, through a 256-entry coefficient-sum ROM; result every 8 clocks.
module distributed_arith #(
  parameter int                   CW = 16,
  parameter logic signed [CW-1:0] H1 = 1,
  parameter logic signed [CW-1:0] H2 = 2,
  parameter logic signed [CW-1:0] H3 = 3,
  parameter logic signed [CW-1:0] H4 = 4,
  parameter logic signed [CW-1:0] H5 = 4,
  parameter logic signed [CW-1:0] H6 = 3,
  parameter logic signed [CW-1:0] H7 = 2,
  parameter logic signed [CW-1:0] H8 = 1
) (
  input  logic               clk3,
  input  logic               reset,
  input  logic signed [7:0]  x1_bit,
  input  logic signed [7:0]  x2_bit,
  input  logic signed [7:0]  x3_bit,
  input  logic signed [7:0]  x4_bit,
  input  logic signed [7:0]  x5_bit,
  input  logic signed [7:0]  x6_bit,
  input  logic signed [7:0]  x7_bit,
  input  logic signed [7:0]  x8_bit,
  output logic signed [31:0] sum
);

  localparam int LW = CW + 3;

  localparam logic signed [CW-1:0] H_TAB [8] = '{H1, H2, H3, H4, H5, H6, H7, H8};

  function automatic logic signed [LW-1:0] lut_entry(input logic [7:0] a);
    logic signed [LW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (a[i]) acc = acc + {{(LW-CW){H_TAB[i][CW-1]}}, H_TAB[i]};
    end
    return acc;
  endfunction

  logic        [2:0]    r_k;
  logic signed [31:0]   r_acc;
  logic signed [31:0]   r_sum;

  logic        [7:0]    w_taps [8];
  logic        [7:0]    w_addr;
  logic signed [LW-1:0] w_lut_rom [256];
  logic signed [LW-1:0] w_lut;
  logic signed [31:0]   w_ext;
  logic signed [31:0]   w_term;

  // Constant ROM: every entry folds to a constant at elaboration.
  for (genvar a = 0; a < 256; a++) begin : g_lut
    assign w_lut_rom[a] = lut_entry(8'(a));
  end

  assign w_taps[0] = x1_bit;
  assign w_taps[1] = x2_bit;
  assign w_taps[2] = x3_bit;
  assign w_taps[3] = x4_bit;
  assign w_taps[4] = x5_bit;
  assign w_taps[5] = x6_bit;
  assign w_taps[6] = x7_bit;
  assign w_taps[7] = x8_bit;

  always_comb begin
    w_addr = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_addr[i] = w_taps[i][r_k];
    end
  end

  assign w_lut  = w_lut_rom[w_addr];
  assign w_ext  = {{(32-LW){w_lut[LW-1]}}, w_lut};
  assign w_term = w_ext <<< r_k;

  // Plane 7 is the two's-complement sign plane, hence the subtraction.
  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      r_k   <= '0;
      r_acc <= '0;
      r_sum <= '0;
    end else begin
      r_k <= r_k + 3'd1;
      case (r_k)
        3'd0:    r_acc <= w_ext;
        3'd7:    r_sum <= r_acc - w_term;
        default: r_acc <= r_acc + w_term;
      endcase
    end
  end

  assign sum = r_sum;

endmodule

// File: tb/tb_distributed_arith.sv
// Directed and random frame checks for distributed_arith against a golden
// inner product, including reset behaviour and a full-scale parameter override.
module tb_distributed_arith;

  logic               clk3 = 1'b0;
  logic               reset;
  logic signed [7:0]  xv [8];
  logic signed [7:0]  xbig;
  logic signed [31:0] sum;
  logic signed [31:0] sum_big;

  int checks   = 0;
  int failures = 0;
  int last_exp = 0;

  localparam int HG [8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  always #5 clk3 = ~clk3;

  distributed_arith dut (
    .clk3   (clk3),
    .reset  (reset),
    .x1_bit (xv[0]),
    .x2_bit (xv[1]),
    .x3_bit (xv[2]),
    .x4_bit (xv[3]),
    .x5_bit (xv[4]),
    .x6_bit (xv[5]),
    .x7_bit (xv[6]),
    .x8_bit (xv[7]),
    .sum    (sum)
  );

  distributed_arith #(
    .CW (16),
    .H1 (-16'sd32768), .H2 (-16'sd32768), .H3 (-16'sd32768), .H4 (-16'sd32768),
    .H5 (-16'sd32768), .H6 (-16'sd32768), .H7 (-16'sd32768), .H8 (-16'sd32768)
  ) dut_big (
    .clk3   (clk3),
    .reset  (reset),
    .x1_bit (xbig),
    .x2_bit (xbig),
    .x3_bit (xbig),
    .x4_bit (xbig),
    .x5_bit (xbig),
    .x6_bit (xbig),
    .x7_bit (xbig),
    .x8_bit (xbig),
    .sum    (sum_big)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 8; i++) xv[i] = 8'(v);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) xv[i] = 8'(i + 1);
  endtask

  function automatic int golden();
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += HG[i] * int'(xv[i]);
    return s;
  endfunction

  // Inputs are already applied; the next rising edge is the frame's k=0 edge.
  task automatic run_frame(input string tag, input int exp);
    repeat (7) @(posedge clk3);
    #1 chk({tag, "_hold"}, sum, last_exp);
    @(posedge clk3);
    #1 chk(tag, sum, exp);
    last_exp = exp;
  endtask

  initial begin
    reset = 1'b1;
    xbig  = -8'sd128;
    for (int i = 0; i < 8; i++) xv[i] = 8'($urandom_range(255));
    #3 chk("reset_async", sum, 0);

    @(negedge clk3);
    reset = 1'b0;
    set_all(0);
    run_frame("zeros", 0);
    chk("big_h", sum_big, 33554432);

    set_all(1);
    run_frame("ones", 20);
    set_ramp();
    run_frame("ramp", 90);
    set_all(0);
    xv[0] = -8'sd128;
    run_frame("x1_neg", -128);
    set_all(-128);
    run_frame("all_neg", -2560);
    set_all(127);
    run_frame("all_pos", 2540);

    set_all(1);
    run_frame("seq_ones", 20);
    set_ramp();
    run_frame("seq_ramp", 90);
    set_all(127);
    run_frame("seq_pos", 2540);

    // Reset arriving after the k=3 edge of an all-127 frame.
    repeat (4) @(posedge clk3);
    #1 reset = 1'b1;
    #1 chk("reset_midframe", sum, 0);
    @(negedge clk3);
    reset    = 1'b0;
    last_exp = 0;
    set_ramp();
    run_frame("after_reset", 90);

    // Reset held across what would be the k=7 edge.
    set_all(127);
    repeat (7) @(posedge clk3);
    #1 reset = 1'b1;
    @(posedge clk3);
    #1 chk("reset_at_k7", sum, 0);
    @(negedge clk3);
    reset    = 1'b0;
    last_exp = 0;

    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 8; i++) xv[i] = 8'($urandom_range(255));
      if (f == 0) xv[0] = -8'sd128;
      if (f == 1) xv[7] = 8'sd127;
      run_frame("random", golden());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
